// File: rtl/demux_row_assembler.sv
// demux_row_assembler: steers a 1-bit pixel stream into a WIDTH-bit row register.
// A bit lands either at an auto-incrementing pointer or at an explicit select.
// Each completed row is presented on a registered valid/ready output and held
// there until the consumer takes it.
module demux_row_assembler #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SEL_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             flush,
    output logic [WIDTH-1:0] out_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SEL_W:0]   out_count
);

    localparam logic [SEL_W-1:0] LastPos  = SEL_W'(WIDTH - 1);
    localparam logic [SEL_W:0]   CountMax = (SEL_W + 1)'(WIDTH);

    typedef enum logic [0:0] {
        StFill,
        StHold
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   row_q, row_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [SEL_W:0]     count_q, count_d;
    logic               out_valid_q, out_valid_d;

    logic               accept;
    logic [SEL_W-1:0]   wr_pos;
    logic               pos_ok;
    logic               wr_en;
    logic               row_last;
    logic               flush_close;
    logic               release_row;

    // Decode the write position and the events that open or close a row
    always_comb begin
        accept      = in_valid & in_ready;
        wr_pos      = mode ? sel : ptr_q;
        // Positions at or beyond WIDTH only occur in addressed mode; those bits are dropped
        pos_ok      = ({1'b0, wr_pos} < CountMax);
        wr_en       = accept & pos_ok;
        row_last    = accept & ~mode & (ptr_q == LastPos);
        // An accept in the flush cycle makes the row non-empty even if count is still zero
        flush_close = (state_q == StFill) & flush & ((count_q != '0) | accept);
        release_row = (state_q == StHold) & out_ready;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: FILL closes on the last auto position or on flush, HOLD waits for ready
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFill: begin
                if (row_last || flush_close) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    state_d = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    // Output logic: bits are only taken while a row is being filled
    always_comb begin
        in_ready    = (state_q == StFill);
        out_valid_d = (state_d == StHold);
    end

    // Row, pointer and count next state
    always_comb begin
        row_d   = row_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (release_row) begin
            row_d   = '0;
            ptr_d   = '0;
            count_d = '0;
        end else begin
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (wr_en && (wr_pos == SEL_W'(i))) begin
                    row_d[i] = in_bit;
                end
            end
            if (wr_en && (count_q != CountMax)) begin
                count_d = count_q + 1'b1;
            end
            // Addressed writes leave the pointer alone so auto mode resumes where it left off
            if (accept && !mode) begin
                ptr_d = row_last ? '0 : ptr_q + 1'b1;
            end
        end
    end

    // Datapath registers; reset discards any partial row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= '0;
            ptr_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            row_q       <= row_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_row   = row_q;
    assign out_count = count_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_demux_row_assembler.sv
// Directed bench for demux_row_assembler: a 16-wide instance driven from a vector table
// and hand sequences, plus a 10-wide instance for the non-power-of-two corner cases.
module tb_demux_row_assembler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 16-wide instance
    logic        a_bit, a_valid, a_ready, a_mode, a_flush, a_ovalid, a_oready;
    logic [3:0]  a_sel;
    logic [15:0] a_row;
    logic [4:0]  a_cnt;

    // 10-wide instance
    logic        b_bit, b_valid, b_ready, b_mode, b_flush, b_ovalid, b_oready;
    logic [3:0]  b_sel;
    logic [9:0]  b_row;
    logic [4:0]  b_cnt;

    demux_row_assembler #(.WIDTH(16), .SEL_W(4)) dut16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_bit   (a_bit),
        .in_valid (a_valid),
        .in_ready (a_ready),
        .mode     (a_mode),
        .sel      (a_sel),
        .flush    (a_flush),
        .out_row  (a_row),
        .out_valid(a_ovalid),
        .out_ready(a_oready),
        .out_count(a_cnt)
    );

    demux_row_assembler #(.WIDTH(10), .SEL_W(4)) dut10 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_bit   (b_bit),
        .in_valid (b_valid),
        .in_ready (b_ready),
        .mode     (b_mode),
        .sel      (b_sel),
        .flush    (b_flush),
        .out_row  (b_row),
        .out_valid(b_ovalid),
        .out_ready(b_oready),
        .out_count(b_cnt)
    );

    typedef struct {
        logic        iv;
        logic        ib;
        logic        md;
        logic [3:0]  sl;
        logic        fl;
        logic        ordy;
        logic        e_irdy;
        logic        e_ov;
        logic [15:0] e_row;
        logic [4:0]  e_cnt;
    } vec_t;

    localparam int NumVec = 22;
    vec_t vecs[NumVec];

    function automatic vec_t mk(logic iv, logic ib, logic md, logic [3:0] sl, logic fl,
                                logic ordy, logic e_irdy, logic e_ov, logic [15:0] e_row,
                                logic [4:0] e_cnt);
        vec_t v;
        v.iv = iv; v.ib = ib; v.md = md; v.sl = sl; v.fl = fl; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_row = e_row; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic iv, input logic ib, input logic md, input logic [3:0] sl,
                           input logic fl, input logic ordy);
        a_valid = iv; a_bit = ib; a_mode = md; a_sel = sl; a_flush = fl; a_oready = ordy;
    endtask

    task automatic drive_b(input logic iv, input logic ib, input logic md, input logic [3:0] sl,
                           input logic fl, input logic ordy);
        b_valid = iv; b_bit = ib; b_mode = md; b_sel = sl; b_flush = fl; b_oready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input logic irdy, input logic ov,
                           input logic [15:0] row, input logic [4:0] cnt);
        chk({tag, ".in_ready"}, 32'(a_ready), 32'(irdy));
        chk({tag, ".out_valid"}, 32'(a_ovalid), 32'(ov));
        chk({tag, ".out_row"}, 32'(a_row), 32'(row));
        chk({tag, ".out_count"}, 32'(a_cnt), 32'(cnt));
    endtask

    task automatic check_b(input string tag, input logic irdy, input logic ov,
                           input logic [9:0] row, input logic [4:0] cnt);
        chk({tag, ".in_ready"}, 32'(b_ready), 32'(irdy));
        chk({tag, ".out_valid"}, 32'(b_ovalid), 32'(ov));
        chk({tag, ".out_row"}, 32'(b_row), 32'(row));
        chk({tag, ".out_count"}, 32'(b_cnt), 32'(cnt));
    endtask

    initial begin
        logic [15:0] exp_row;

        //                iv ib md sel   fl ordy  irdy ov  row       cnt
        // Addressed writes 1@3, 1@15, 0@3, then flush
        vecs[0]  = mk(1, 1, 1, 4'd3,  0, 0,   1, 0, 16'h0008, 5'd1);
        vecs[1]  = mk(1, 1, 1, 4'd15, 0, 0,   1, 0, 16'h8008, 5'd2);
        vecs[2]  = mk(1, 0, 1, 4'd3,  0, 0,   1, 0, 16'h8000, 5'd3);
        vecs[3]  = mk(0, 0, 1, 4'd0,  1, 0,   0, 1, 16'h8000, 5'd3);
        vecs[4]  = mk(0, 0, 0, 4'd0,  0, 1,   1, 0, 16'h0000, 5'd0);
        // Five auto ones, flush, HOLD ignores flush/valid, then empty flushes are ignored
        vecs[5]  = mk(1, 1, 0, 4'd0,  0, 0,   1, 0, 16'h0001, 5'd1);
        vecs[6]  = mk(1, 1, 0, 4'd0,  0, 0,   1, 0, 16'h0003, 5'd2);
        vecs[7]  = mk(1, 1, 0, 4'd0,  0, 0,   1, 0, 16'h0007, 5'd3);
        vecs[8]  = mk(1, 1, 0, 4'd0,  0, 0,   1, 0, 16'h000F, 5'd4);
        vecs[9]  = mk(1, 1, 0, 4'd0,  0, 0,   1, 0, 16'h001F, 5'd5);
        vecs[10] = mk(0, 0, 0, 4'd0,  1, 0,   0, 1, 16'h001F, 5'd5);
        vecs[11] = mk(1, 1, 1, 4'd9,  1, 0,   0, 1, 16'h001F, 5'd5);
        vecs[12] = mk(0, 0, 0, 4'd0,  0, 1,   1, 0, 16'h0000, 5'd0);
        vecs[13] = mk(0, 0, 0, 4'd0,  1, 0,   1, 0, 16'h0000, 5'd0);
        vecs[14] = mk(0, 0, 0, 4'd0,  1, 0,   1, 0, 16'h0000, 5'd0);
        // Bit accepted in the flush cycle is part of the presented row
        vecs[15] = mk(1, 1, 0, 4'd0,  1, 0,   0, 1, 16'h0001, 5'd1);
        vecs[16] = mk(0, 0, 0, 4'd0,  0, 1,   1, 0, 16'h0000, 5'd0);
        // Mode switch mid-row: addressed write leaves the pointer at 0
        vecs[17] = mk(1, 1, 1, 4'd7,  0, 0,   1, 0, 16'h0080, 5'd1);
        vecs[18] = mk(1, 1, 0, 4'd0,  0, 0,   1, 0, 16'h0081, 5'd2);
        vecs[19] = mk(1, 1, 0, 4'd0,  0, 0,   1, 0, 16'h0083, 5'd3);
        vecs[20] = mk(0, 0, 0, 4'd0,  1, 0,   0, 1, 16'h0083, 5'd3);
        vecs[21] = mk(0, 0, 0, 4'd0,  0, 1,   1, 0, 16'h0000, 5'd0);

        drive_a(0, 0, 0, 4'd0, 0, 0);
        drive_b(0, 0, 0, 4'd0, 0, 0);
        #3;
        check_a("reset16", 1, 0, 16'h0000, 5'd0);
        check_b("reset10", 1, 0, 10'h000, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: 16 back-to-back auto bits, bit i = ~i[0]
        for (int i = 0; i < 16; i++) begin
            drive_a(1, ~i[0], 0, 4'd0, 0, 0);
            tick();
            if (i < 15) begin
                chk($sformatf("t1.ov%0d", i), 32'(a_ovalid), 32'd0);
                chk($sformatf("t1.cnt%0d", i), 32'(a_cnt), 32'(i + 1));
            end
        end
        check_a("t1.full", 0, 1, 16'h5555, 5'd16);

        // T2: backpressure with the source still offering a 1
        for (int k = 0; k < 5; k++) begin
            drive_a(1, 1, 0, 4'd0, 0, 0);
            tick();
            check_a($sformatf("t2.hold%0d", k), 0, 1, 16'h5555, 5'd16);
        end
        drive_a(1, 1, 0, 4'd0, 0, 1);
        tick();
        check_a("t2.release", 1, 0, 16'h0000, 5'd0);
        drive_a(1, 1, 0, 4'd0, 0, 0);
        tick();
        check_a("t2.first", 1, 0, 16'h0001, 5'd1);

        // T5: bring the row to 7 auto bits, then reset asynchronously mid-cycle
        for (int i = 0; i < 6; i++) begin
            drive_a(1, 1, 0, 4'd0, 0, 0);
            tick();
        end
        check_a("t5.seven", 1, 0, 16'h007F, 5'd7);
        drive_a(0, 0, 0, 4'd0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_a("t5.async", 1, 0, 16'h0000, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_row = '0;
        for (int i = 0; i < 16; i++) begin
            drive_a(1, i[0], 0, 4'd0, 0, 0);
            exp_row[i] = i[0];
            tick();
        end
        check_a("t5.row", 0, 1, exp_row, 5'd16);
        drive_a(0, 0, 0, 4'd0, 0, 1);
        tick();
        check_a("t5.clear", 1, 0, 16'h0000, 5'd0);

        // Table vectors: addressed writes, flush corners, mode switching
        for (int i = 0; i < NumVec; i++) begin
            drive_a(vecs[i].iv, vecs[i].ib, vecs[i].md, vecs[i].sl, vecs[i].fl, vecs[i].ordy);
            tick();
            check_a($sformatf("vec%0d", i), vecs[i].e_irdy, vecs[i].e_ov, vecs[i].e_row,
                    vecs[i].e_cnt);
        end
        drive_a(0, 0, 0, 4'd0, 0, 0);

        // T6: WIDTH=10, out-of-range select is dropped
        drive_b(1, 1, 1, 4'd12, 0, 0);
        tick();
        check_b("t6.drop", 1, 0, 10'h000, 5'd0);
        drive_b(1, 1, 1, 4'd9, 0, 0);
        tick();
        check_b("t6.top", 1, 0, 10'h200, 5'd1);
        drive_b(1, 1, 1, 4'd10, 0, 0);
        tick();
        check_b("t6.drop2", 1, 0, 10'h200, 5'd1);
        drive_b(0, 0, 0, 4'd0, 1, 0);
        tick();
        check_b("t6.flush", 0, 1, 10'h200, 5'd1);
        drive_b(0, 0, 0, 4'd0, 0, 1);
        tick();
        check_b("t6.clear", 1, 0, 10'h000, 5'd0);

        // T6: auto row completes after 10 accepts
        for (int i = 0; i < 10; i++) begin
            drive_b(1, 1, 0, 4'd0, 0, 0);
            tick();
            if (i < 9) begin
                chk($sformatf("t6.auto_ov%0d", i), 32'(b_ovalid), 32'd0);
            end
        end
        check_b("t6.auto", 0, 1, 10'h3FF, 5'd10);
        drive_b(0, 0, 0, 4'd0, 0, 1);
        tick();
        check_b("t6.clear2", 1, 0, 10'h000, 5'd0);

        // Count saturates at WIDTH under repeated addressed writes
        for (int i = 0; i < 12; i++) begin
            drive_b(1, 1, 1, 4'd0, 0, 0);
            tick();
        end
        check_b("sat.fill", 1, 0, 10'h001, 5'd10);
        drive_b(0, 0, 0, 4'd0, 1, 0);
        tick();
        check_b("sat.flush", 0, 1, 10'h001, 5'd10);
        drive_b(0, 0, 0, 4'd0, 0, 1);
        tick();
        check_b("sat.clear", 1, 0, 10'h000, 5'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
